// File: rtl/sensor_conditioner.sv
// sensor_conditioner: synchronises, debounces and stuck-checks the four vehicle sensors,
// then qualifies per-road presence with a hold time for the traffic light controller.
module sensor_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int HOLD_CYCLES     = 250,
  parameter int STUCK_CYCLES    = 1000,
  parameter int CNT_W           = 20
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       AS1,
  input  logic       AS2,
  input  logic       BS1,
  input  logic       BS2,
  output logic       AS,
  output logic       BS,
  output logic [1:0] sensor_combo,
  output logic       combo_change,
  output logic [3:0] sensor_db,
  output logic [3:0] sensor_fault
);
  typedef enum logic [1:0] {ABSENT, PRESENT, HOLD} road_t;
  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] STK       = CNT_W'(STUCK_CYCLES);
  localparam logic [CNT_W-1:0] STK_LAST  = CNT_W'(STUCK_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  logic [3:0] raw, masked;
  logic [1:0] road_raw, pres, combo_q;
  assign raw = {BS2, BS1, AS2, AS1};
  for (genvar i = 0; i < 4; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sq;
    logic [CNT_W-1:0] dc, sc;
    logic db_q, f_q, s;
    assign s = sq[SYNC_STAGES-1];
    always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
        sq   <= '0;
        dc   <= '0;
        sc   <= '0;
        db_q <= 1'b0;
        f_q  <= 1'b0;
      end else begin
        sq   <= {sq[SYNC_STAGES-2:0], raw[i]};
        dc   <= (s == db_q || dc == DB_LAST) ? '0 : dc + 1'b1;
        db_q <= (s != db_q && dc == DB_LAST) ? s : db_q;
        sc   <= !db_q ? '0 : (sc == STK ? sc : sc + 1'b1);
        f_q  <= db_q & (f_q | sc == STK_LAST);
      end
    assign sensor_db[i]    = db_q;
    assign sensor_fault[i] = f_q;
  end
  assign masked   = sensor_db & ~sensor_fault;
  assign road_raw = {|masked[3:2], |masked[1:0]};
  for (genvar r = 0; r < 2; r++) begin : g_road
    road_t st, st_nx;
    logic [CNT_W-1:0] hc, hc_nx;
    always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
        st <= ABSENT;
        hc <= '0;
      end else begin
        st <= st_nx;
        hc <= hc_nx;
      end
    always_comb begin
      st_nx = st;
      hc_nx = hc;
      case (st)
        ABSENT:  st_nx = road_raw[r] ? PRESENT : ABSENT;
        PRESENT: if (!road_raw[r]) begin
          st_nx = (HOLD_CYCLES == 0) ? ABSENT : HOLD;
          hc_nx = HOLD_LOAD;
        end
        HOLD: if (road_raw[r]) st_nx = PRESENT;
          else if (hc == '0) st_nx = ABSENT;
          else hc_nx = hc - 1'b1;
        default: st_nx = ABSENT;
      endcase
    end
    assign pres[r] = (st != ABSENT);
  end
  assign AS           = pres[0];
  assign BS           = pres[1];
  assign sensor_combo = {AS, BS};
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      combo_q      <= 2'b00;
      combo_change <= 1'b0;
    end else begin
      combo_q      <= sensor_combo;
      combo_change <= (sensor_combo != combo_q);
    end
endmodule

// File: tb/tb_sensor_conditioner.sv
// tb_sensor_conditioner: directed checks of debounce, hold, stuck detection and combo strobe.
module tb_sensor_conditioner;
  logic clk = 1'b0;
  logic reset_n, AS1, AS2, BS1, BS2;
  logic AS, BS, combo_change;
  logic [1:0] sensor_combo;
  logic [3:0] sensor_db, sensor_fault;
  int n_pass = 0;
  int n_chk  = 0;
  logic seen;

  sensor_conditioner dut (
    .clk(clk), .reset_n(reset_n),
    .AS1(AS1), .AS2(AS2), .BS1(BS1), .BS2(BS2),
    .AS(AS), .BS(BS), .sensor_combo(sensor_combo), .combo_change(combo_change),
    .sensor_db(sensor_db), .sensor_fault(sensor_fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; AS1 = 0; AS2 = 0; BS1 = 0; BS2 = 0;
    cyc(3);
    check("rst_db", sensor_db, 4'h0);
    check("rst_combo", sensor_combo, 2'b00);
    check("rst_fault", sensor_fault, 4'h0);
    check("rst_change", combo_change, 1'b0);
    reset_n = 1'b1;
    cyc(5);
    check("post_rst_combo", {AS, BS, combo_change}, 3'b000);
    // 1: 10-cycle glitch must be rejected
    seen = 1'b0;
    AS1 = 1;
    repeat (10) begin cyc(1); seen |= sensor_db[0] | AS | combo_change; end
    AS1 = 0;
    repeat (30) begin cyc(1); seen |= sensor_db[0] | AS | combo_change; end
    check("glitch", seen, 1'b0);
    // 2: steady AS1, latency 18 edges, presence one edge later, one-cycle strobe
    AS1 = 1;
    cyc(17);
    check("db_edge17", sensor_db[0], 1'b0);
    cyc(1);
    check("db_edge18", sensor_db[0], 1'b1);
    check("as_edge18", AS, 1'b0);
    cyc(1);
    check("as_edge19", AS, 1'b1);
    check("combo_10", sensor_combo, 2'b10);
    check("chg_edge19", combo_change, 1'b0);
    cyc(1);
    check("chg_edge20", combo_change, 1'b1);
    cyc(1);
    check("chg_edge21", combo_change, 1'b0);
    AS1 = 0;
    cyc(300);
    check("as_released", AS, 1'b0);
    // 3a: BS hold of 250 cycles after PRESENT->HOLD
    BS2 = 1;
    cyc(19);
    check("bs_rise", BS, 1'b1);
    BS2 = 0;
    cyc(268);
    check("bs_hold_end", BS, 1'b1);
    cyc(1);
    check("bs_fall", BS, 1'b0);
    cyc(20);
    // 3b: BS1 returns during hold, BS never drops
    BS2 = 1;
    cyc(19);
    BS2 = 0;
    seen = 1'b0;
    repeat (119) begin cyc(1); seen |= ~BS; end
    BS1 = 1;
    repeat (30) begin cyc(1); seen |= ~BS; end
    BS1 = 0;
    repeat (250) begin cyc(1); seen |= ~BS; end
    check("bs_retrigger", seen, 1'b0);
    cyc(200);
    check("bs_retrig_fall", BS, 1'b0);
    // 4: AS2 stuck high
    AS2 = 1;
    cyc(1017);
    check("fault_pre", sensor_fault, 4'h0);
    check("as_pre_fault", AS, 1'b1);
    cyc(1);
    check("fault_set", sensor_fault, 4'b0010);
    cyc(250);
    check("as_masked_hold", AS, 1'b1);
    cyc(1);
    check("as_masked_fall", AS, 1'b0);
    AS2 = 0;
    cyc(18);
    check("fault_db_low", {sensor_db[1], sensor_fault[1]}, 2'b01);
    cyc(1);
    check("fault_clear", sensor_fault, 4'h0);
    cyc(5);
    // 5: simultaneous rise gives a single strobe
    AS1 = 1; BS1 = 1;
    cyc(18);
    check("combo_pre", sensor_combo, 2'b00);
    cyc(1);
    check("combo_11", sensor_combo, 2'b11);
    cyc(1);
    check("combo_pulse", combo_change, 1'b1);
    cyc(1);
    check("combo_pulse_end", combo_change, 1'b0);
    AS1 = 0; BS1 = 0;
    cyc(300);
    check("combo_idle", sensor_combo, 2'b00);
    // 6: reset mid-hold and mid-debounce
    BS2 = 1;
    cyc(19);
    BS2 = 0;
    cyc(69);
    AS1 = 1;
    cyc(8);
    reset_n = 1'b0;
    #1;
    check("async_rst", {AS, BS, combo_change, sensor_combo, sensor_db}, 9'h0);
    AS1 = 0;
    cyc(2);
    reset_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin cyc(1); seen |= AS | BS | combo_change | (|sensor_db); end
    check("rst_clean", seen, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/sensor_conditioner.md
Name: sensor_conditioner

Overview:
Upstream front end for the traffic light controller. It synchronises and debounces the four raw vehicle sensors AS1/AS2/BS1/BS2. Per road, it qualifies vehicle presence with a hold time so the controller does not thrash on gaps between cars. It detects and masks sensors stuck high, and delivers clean AS/BS, the 2-bit sensor_combo {AS,BS}, and a change strobe to the controller and the LCD status digits.

Parameters:
SYNC_STAGES, 2, synchroniser flops per raw input (min 2)
DEBOUNCE_CYCLES, 16, consecutive cycles of a differing synced level needed to flip the debounced level (use 1_000_000 on board, i.e. 20 ms @ 50 MHz); min 1
HOLD_CYCLES, 250, cycles a road stays "present" after its last sensor drops; 0 = no hold
STUCK_CYCLES, 1000, continuous debounced-high cycles after which a sensor is declared stuck
CNT_W, 20, width of all internal counters; must hold the largest of the above

Ports:
clk  in  1  system clock (50 MHz)
reset_n  in  1  asynchronous, active-low reset
AS1, AS2  in  1  main-road raw sensors (asynchronous, may bounce)
BS1, BS2  in  1  side-road raw sensors (asynchronous, may bounce)
AS  out  1  qualified main-road presence
BS  out  1  qualified side-road presence
sensor_combo  out  2  {AS, BS}
combo_change  out  1  one-cycle pulse, registered
sensor_db  out  4  debounced levels {BS2, BS1, AS2, AS1}
sensor_fault  out  4  stuck flags, same bit order

Behaviour:
- Reset (reset_n low, asynchronous): all sync flops, debounced levels, counters, faults and combo_change go to 0; both road FSMs go to ABSENT. Outputs therefore read AS=BS=0, sensor_combo=00 and sensor_db=0 while reset is held and after release.
- Sync: each raw input passes through an SYNC_STAGES flop chain, reset value 0.
- Debounce, per input:
  - Counter clears on any cycle where the synced value equals the debounced level.
  - While the synced value differs, the counter increments.
  - On the edge where the counter equals DEBOUNCE_CYCLES-1 and the values still differ, the debounced level takes the synced value and the counter clears.
  - Latency: sensor_db changes on the (SYNC_STAGES+DEBOUNCE_CYCLES)-th rising edge that samples a steady new level (default: the 18th). Any shorter pulse is fully rejected.
- Stuck detect, per input:
  - Saturating counter increments while the debounced level is 1 and clears when it is 0.
  - When the counter reaches STUCK_CYCLES, the fault bit sets on that edge.
  - A fault bit clears on the edge after its debounced level returns to 0.
  - Faulted inputs are masked (treated as 0) in the road logic.
- Road raw: A_raw = (db_AS1 & ~f_AS1) | (db_AS2 & ~f_AS2); B_raw likewise.
- Road FSM, per road (ABSENT, PRESENT, HOLD):
  - ABSENT: raw=1 -> PRESENT.
  - PRESENT: raw=0 -> HOLD, loading hold counter with HOLD_CYCLES-1. If HOLD_CYCLES=0, go directly to ABSENT.
  - HOLD: raw=1 -> PRESENT (counter discarded). Otherwise, counter==0 -> ABSENT, else decrement.
  - The road output is (state != ABSENT), decoded from registered state with no combinational path from inputs.
  - Presence rises the edge after raw rises, and falls HOLD_CYCLES edges after the PRESENT->HOLD edge.
- combo_change: registered; 1 for exactly one cycle on the edge after sensor_combo differs from its previous-cycle value. Simultaneous AS and BS changes produce one pulse. No pulse results from reset assertion or release.
- Reset asserted mid-debounce or mid-hold aborts everything; no residual state survives.

Test Plan:
1. Glitch: AS1=1 for 10 cycles then 0 -> sensor_db[0], AS and combo_change stay 0 throughout.
2. Steady AS1=1 -> sensor_db[0] rises on the 18th sampling edge, AS rises one edge later, sensor_combo=10, combo_change high for exactly 1 cycle after that.
3. BS2 high (BS=1), then BS2=0 -> BS stays 1 for 250 cycles after the PRESENT->HOLD edge, then 0. In a second run, BS1 pulses steady high for 30 cycles at hold cycle 100 -> BS never drops.
4. AS2 held 1 -> sensor_fault[1]=1 once the stuck count reaches 1000. AS then drops HOLD_CYCLES later with AS1=0. Releasing AS2 clears the fault once the debounced level returns to 0.
5. AS1 and BS1 rise in the same cycle -> sensor_combo goes 00 -> 11 in one step, with a single combo_change pulse.
6. reset_n pulsed low during a BS hold and a partial AS1 debounce -> all outputs are 0 immediately, with no combo_change pulse after release.
